// File: rtl/truth_table_preimage_finder_if.sv
// Handshake bundle between a search requester and the truth-table preimage finder.
// The requester drives start/abort/targets/match_ready; the finder drives the rest.
interface truth_table_preimage_finder_if;
    logic       start;
    logic       abort;
    logic       tgt_f1;
    logic       tgt_f2;
    logic       busy;
    logic       match_valid;
    logic       match_ready;
    logic [3:0] match_abcd;
    logic [4:0] match_count;
    logic       done;

    modport master (
        output start, abort, tgt_f1, tgt_f2, match_ready,
        input  busy, match_valid, match_abcd, match_count, done
    );

    modport slave (
        input  start, abort, tgt_f1, tgt_f2, match_ready,
        output busy, match_valid, match_abcd, match_count, done
    );
endinterface

// File: rtl/truth_table_preimage_finder.sv
// Walks all 16 {A,B,C,D} inputs of the fixed F1/F2 function pair and streams every
// vector that yields the requested (F1,F2) over a valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; outputs idle, match_count holds last result
// SCAN  | evaluating F1/F2 at idx
// HOLD  | match_abcd presented, waiting for match_ready
// DONE  | one-cycle done pulse, then back to IDLE
module truth_table_preimage_finder #(
    parameter bit STOP_ON_FIRST = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    truth_table_preimage_finder_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, HOLD, DONE} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] idx;
    logic       tgt_f1_q;
    logic       tgt_f2_q;
    logic [3:0] abcd_q;
    logic [4:0] count_q;
    logic       f1_eval;
    logic       f2_eval;
    logic       hit;
    logic       last;
    logic       accept;

    // idx bit order is {A,B,C,D}
    assign f2_eval = (~idx[3] & idx[2]) | idx[0];
    assign f1_eval = idx[3] | idx[2] | (idx[0] ^ (~idx[2] & idx[1]));
    assign hit     = (f1_eval == tgt_f1_q) && (f2_eval == tgt_f2_q);
    assign last    = (idx == 4'd15);
    assign accept  = (state == HOLD) && bus.match_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.abort) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: if (bus.start) state_nxt = SCAN;
                SCAN: begin
                    if (hit)       state_nxt = HOLD;
                    else if (last) state_nxt = DONE;
                end
                HOLD: begin
                    if (accept) state_nxt = (last || STOP_ON_FIRST) ? DONE : SCAN;
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Abort freezes the datapath so a partial match_count stays visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= 4'd0;
            tgt_f1_q <= 1'b0;
            tgt_f2_q <= 1'b0;
            abcd_q   <= 4'd0;
            count_q  <= 5'd0;
        end else if (!bus.abort) begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tgt_f1_q <= bus.tgt_f1;
                        tgt_f2_q <= bus.tgt_f2;
                        idx      <= 4'd0;
                        count_q  <= 5'd0;
                    end
                end
                SCAN: begin
                    if (hit)        abcd_q <= idx;
                    else if (!last) idx    <= idx + 4'd1;
                end
                HOLD: begin
                    if (accept) begin
                        count_q <= count_q + 5'd1;
                        if (!last && !STOP_ON_FIRST) idx <= idx + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.busy        = (state != IDLE);
        bus.match_valid = (state == HOLD);
        bus.done        = (state == DONE);
        bus.match_abcd  = abcd_q;
        bus.match_count = count_q;
    end

endmodule

// File: doc/truth_table_preimage_finder.md
# truth_table_preimage_finder

Sequential inverse of the team's four-input combinational function block: given a requested output pair (F1, F2), it walks all 16 input combinations {A,B,C,D}, evaluates the same two Boolean functions internally, and streams out every input vector that produces the requested pair. Each match is delivered over a valid/ready handshake, followed by a count and a done pulse. It sits beside the function block as a self-check and lookup engine for lab benches and higher-level controllers.

## Interface
Parameters:
- STOP_ON_FIRST, default 0: 1 = finish after the first accepted match; 0 = report all matches.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a search; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE with no done pulse.
- tgt_f1  in  1  requested F1 value; captured on accepted start.
- tgt_f2  in  1  requested F2 value; captured on accepted start.
- busy  out  1  high in SCAN, HOLD and DONE.
- match_valid  out  1  match_abcd holds a matching vector.
- match_ready  in  1  consumer accepts the match when it is high together with match_valid.
- match_abcd  out  4  matching vector: [3]=A, [2]=B, [1]=C, [0]=D.
- match_count  out  5  number of matches accepted in the current or last search (0..16).
- done  out  1  one-cycle pulse at the end of a search.

## Operation
- Evaluated functions, fixed:
  - F2 = (~A & B) | D
  - F1 = (A | B) | (D ^ (~B & C))
- Internal state: 4-bit index idx, registered targets, 5-bit match_count, FSM {IDLE, SCAN, HOLD, DONE}.
- IDLE:
  - If start is high (and abort is low): capture tgt_f1/tgt_f2, set idx=0, clear match_count, go to SCAN.
  - Otherwise stay in IDLE.
- SCAN: evaluate F1/F2 at idx.
  - On a match: register match_abcd=idx, set match_valid=1, go to HOLD.
  - No match, idx<15: idx+1, stay in SCAN.
  - No match, idx==15: go to DONE.
- HOLD: match_valid and match_abcd stay stable until match_ready is high.
  - On handshake: match_valid=0, match_count+1.
  - Next state: DONE if idx==15 or STOP_ON_FIRST=1; otherwise idx+1 and SCAN.
- DONE: done=1 for exactly one cycle, then IDLE.
  - match_count holds its value until the next accepted start.
- abort, highest priority after rst: at the next edge go to IDLE; match_valid=0, done=0; match_count holds its partial value.
- start outside IDLE is ignored. Target inputs are ignored except on the start edge.
- idx never wraps. The search ends at 15.

## Timing
- Reset values: busy=0, match_valid=0, match_abcd=0, match_count=0, done=0, state IDLE, idx=0.
- rst asserted mid-search returns every output to its reset value immediately (asynchronous). No done pulse is produced.
- Latency with match_ready held high:
  - Non-matching index: 1 cycle.
  - Matching index: 2 cycles (SCAN + HOLD).
  - A full search occupies 16+N cycles, where N = match count; done rises in the following cycle.
- match_valid is first high in the cycle after the SCAN cycle that found the match.
- match_ready low stalls in HOLD indefinitely. No match is dropped or duplicated.
- busy goes high in the cycle after start is sampled and drops with the return to IDLE (it is high during the done cycle).
- start asserted in the done cycle is ignored. start must be presented in IDLE.

## Test plan
- Targets (0,0), ready held high -> single match 0000; match_count=1; done 18 cycles after the start edge.
- Targets (0,1) -> single match 0011; match_count=1.
- Targets (1,0) -> matches in order 2,8,10,12,14; match_count=5; done at start+22.
- Targets (1,1) with match_ready toggling 1 cycle on, 2 off -> nine matches 1,4,5,6,7,9,11,13,15 in order; match_abcd stable during stalls; match_count=9.
- STOP_ON_FIRST=1, targets (1,1) -> only 0001 reported; match_count=1; done follows the handshake.
- Mid-search cases:
  - rst during HOLD -> all outputs 0 immediately.
  - abort during SCAN -> IDLE next edge, no done pulse.
  - start while busy -> ignored.
